alu_nbit_seq: RTL
=================

# alu_nbit_seq

Parametrised, clocked successor to the 4-bit combinational ALU. It registers operands and results behind a valid/ready handshake on both sides, and adds status flags. An optional iterative multiplier is compiled in with a macro. It sits between an operand source and a result consumer, and either side can stall it.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request this cycle.
- sel  in  4  operation select, sampled on accept.
- A  in  WIDTH  operand A, sampled on accept.
- B  in  WIDTH  operand B, sampled on accept.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- Y  out  WIDTH  result.
- carry  out  1  carry / borrow / shifted-out bit / multiply high-half nonzero.
- zero  out  1  Y == 0.
- negative  out  1  Y[WIDTH-1].
- overflow  out  1  signed overflow (ADD/SUB only; 0 otherwise).

## Operation
- Accept: in_valid && in_ready at a rising edge captures sel, A and B. Later changes on the inputs are ignored.
- sel encoding and results (carry / overflow):
  - 0 ADD: {carry,Y} = A+B. overflow = (A[msb]==B[msb]) && (Y[msb]!=A[msb]).
  - 1 SUB: Y = A-B mod 2^WIDTH. carry = borrow (A<B unsigned). overflow = (A[msb]!=B[msb]) && (Y[msb]!=A[msb]).
  - 2 AND, 3 OR, 4 XOR, 5 NOT A: carry=0, overflow=0.
  - 6 SHL B: Y = B<<1, carry = B[WIDTH-1].
  - 7 SHR B (logical): Y = B>>1, carry = B[0].
  - 8 MUL (only with macro): Y = low WIDTH bits of A*B (unsigned), carry = |high WIDTH bits.
  - 9..15, or 8 without macro: reserved. Y=0, all flags 0 except zero=1. Single-cycle.
- zero and negative are always derived from the registered Y.
- FSM states:
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → BUSY on accept of MUL.
  - BUSY → DONE when the iteration counter reaches WIDTH-1.
  - DONE → IDLE when out_ready=1 and no new accept.
  - DONE → DONE/BUSY when out_ready=1 and a new request is accepted in the same cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and has no path from in_valid.
- out_valid = (state==DONE). Y and flags are held stable while out_valid=1 && out_ready=0.
- MUL datapath: shift-add, one multiplier bit per cycle. Accumulator is 2*WIDTH bits. Counter is ceil(log2(WIDTH)) bits.

## Timing
- Reset values: state IDLE, out_valid=0, Y=0, carry=0, zero=0, negative=0, overflow=0, counter=0. in_ready=1 while rst is low and state is IDLE.
- Single-cycle op: accepted at edge k → out_valid=1 after edge k+1.
- MUL: accepted at edge k → out_valid=1 after edge k+WIDTH+1. in_ready=0 throughout BUSY.
- Back-to-back single-cycle ops with out_ready=1 sustain one result per cycle. out_valid stays 1 and Y updates every edge.
- Backpressure: out_ready=0 in DONE holds the result and forces in_ready=0. No request is lost or overwritten.
- Reset asserted mid-MUL or in DONE aborts immediately. Any pending result is discarded and all outputs return to their reset values.

## Configuration
- ALU_MUL_EN defined:
  - Includes the BUSY state, the counter and the shift-add multiplier.
  - sel=8 performs MUL with latency WIDTH+1.
- ALU_MUL_EN undefined:
  - No BUSY state or multiplier logic is synthesised.
  - sel=8 is reserved: Y=0, zero=1, other flags 0, latency 1.

## Test plan
- Reset, then ADD 0xF0+0x20 (WIDTH=8) → one cycle after accept: Y=0x10, carry=1, zero=0, overflow=0, out_valid=1.
- ADD 0x7F+0x01 → Y=0x80, negative=1, overflow=1, carry=0. SUB 0x03-0x05 → Y=0xFE, carry=1, negative=1, overflow=0.
- SHL B=0x81 → Y=0x02, carry=1. SHR B=0x81 → Y=0x40, carry=1. NOT A=0xFF → Y=0x00, zero=1.
- Hold out_ready=0 after an ADD result and present a second request → in_ready=0, Y stays unchanged for 5 cycles. Raise out_ready → second request is accepted that cycle, and its result appears on the next edge.
- With ALU_MUL_EN: MUL 0x0F*0x11 → Y=0xFF, carry=0 after 9 edges. MUL 0x10*0x10 → Y=0x00, carry=1, zero=1. Assert rst at cycle 4 of a MUL → out_valid=0, Y=0, in_ready=1 after release.
- Without ALU_MUL_EN: sel=8 with A=0x03, B=0x04 → Y=0x00, zero=1, carry=0, out_valid one cycle after accept.

Source files
------------

// File: rtl/alu_nbit_seq.sv
// Clocked WIDTH-bit ALU with valid/ready handshakes on both sides and status flags.
// Define ALU_MUL_EN to build in the iterative shift-add multiplier (sel=8).
module alu_nbit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);
    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DONE = 2'd2;
`ifdef ALU_MUL_EN
    localparam logic [1:0] BUSY = 2'd1;
    localparam int CW = $clog2(WIDTH);
`endif

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             c;
        logic             v;
    } res_t;

    logic [1:0]       state;
    logic [WIDTH-1:0] y_q;
    logic             c_q;
    logic             v_q;
    res_t             res;
    logic             accept;
    logic             is_mul;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign Y        = y_q;
    assign carry    = c_q;
    assign overflow = v_q;
    // zero is qualified by out_valid so the reset state reads as all-flags-clear
    assign zero     = out_valid && (y_q == '0);
    assign negative = y_q[MSB];

`ifdef ALU_MUL_EN
    assign is_mul = (sel == 4'd8);
`else
    assign is_mul = 1'b0;
`endif

    // Single-cycle operations evaluated directly from the request being accepted
    always_comb begin
        res = '0;
        case (sel)
            OP_ADD: begin
                {res.c, res.y} = {1'b0, A} + {1'b0, B};
                res.v = (A[MSB] == B[MSB]) && (res.y[MSB] != A[MSB]);
            end
            OP_SUB: begin
                res.y = A - B;
                res.c = (A < B);
                res.v = (A[MSB] != B[MSB]) && (res.y[MSB] != A[MSB]);
            end
            OP_AND: res.y = A & B;
            OP_OR:  res.y = A | B;
            OP_XOR: res.y = A ^ B;
            OP_NOT: res.y = ~A;
            OP_SHL: begin
                res.y = {B[WIDTH-2:0], 1'b0};
                res.c = B[MSB];
            end
            OP_SHR: begin
                res.y = {1'b0, B[WIDTH-1:1]};
                res.c = B[0];
            end
            default: res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    // acc = {partial product high half, remaining multiplier bits}
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     psum;

    always_comb begin
        psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_nxt = {psum, acc[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            y_q   <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
`ifdef ALU_MUL_EN
            acc   <= '0;
            mcand <= '0;
            cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (is_mul) begin
`ifdef ALU_MUL_EN
                            state <= BUSY;
                            acc   <= {{WIDTH{1'b0}}, B};
                            mcand <= A;
                            cnt   <= '0;
`endif
                        end else begin
                            state <= DONE;
                            y_q   <= res.y;
                            c_q   <= res.c;
                            v_q   <= res.v;
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    // the final step's product goes straight to the result registers
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        cnt   <= '0;
                        y_q   <= acc_nxt[WIDTH-1:0];
                        c_q   <= |acc_nxt[2*WIDTH-1:WIDTH];
                        v_q   <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
